// File: rtl/hid_ex.sv
// HID bridge between the IO MCU byte link and the retro core: frame decoder,
// key-event FIFO with per-event hold time, joystick/mouse registers, DB9 reporting.
module hid_ex #(
    parameter int NUM_JOY     = 2,
    parameter int NUM_DB9     = 1,
    parameter int MATRIX_COLS = 8,
    parameter int MATRIX_ROWS = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int HOLD_CYCLES = 32000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           data_in_strobe,
    input  logic                           data_in_start,
    input  logic [7:0]                     data_in,
    output logic [7:0]                     data_out,
    input  logic [6*NUM_DB9-1:0]           db9_port,
    output logic                           irq,
    input  logic                           iack,
    output logic [6:0]                     keymap_code,
    input  logic [$clog2(MATRIX_COLS)-1:0] keymap_col,
    input  logic [$clog2(MATRIX_ROWS)-1:0] keymap_row,
    input  logic [MATRIX_COLS-1:0]         keyboard_matrix_out,
    output logic [MATRIX_ROWS-1:0]         keyboard_matrix_in,
    output logic [8*NUM_JOY-1:0]           joystick,
    output logic [8*NUM_JOY-1:0]           joystick_ax,
    output logic [8*NUM_JOY-1:0]           joystick_ay,
    output logic [8*NUM_JOY-1:0]           extra_button,
    output logic [NUM_JOY-1:0]             joystick_strobe,
    output logic [7:0]                     numpad,
    output logic                           mod_key,
    output logic                           key_restore,
    output logic                           tape_play,
    output logic [1:0]                     mouse_btns,
    output logic [7:0]                     mouse_x,
    output logic [7:0]                     mouse_y,
    output logic                           mouse_strobe,
    output logic                           fifo_overflow
);

    localparam int CW = $clog2(MATRIX_COLS);
    localparam int RW = $clog2(MATRIX_ROWS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 1 + CW + RW;
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [0:0]  S_IDLE   = 1'b0;
    localparam logic [0:0]  S_HOLD   = 1'b1;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    logic [7:0]    cmd;
    logic [3:0]    state;
    logic [7:0]    dev;
    logic          payload, push_req, push_ok, pop, flush, status_rd, irq_arm;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level;
    logic [3:0]    level_lo;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] push_entry, pop_entry;
    logic [0:0]    drain_state;
    logic [HW-1:0] hold_cnt;
    logic [MATRIX_COLS-1:0][MATRIX_ROWS-1:0] mat;
    logic [6*NUM_DB9-1:0] db9_s1, db9_s2, db9_prev;
    logic          irq_enable;

    assign keymap_code = data_in[6:0];
    assign mod_key     = numpad[5];
    assign key_restore = numpad[6];
    assign tape_play   = numpad[7];

    assign payload    = data_in_strobe && !data_in_start;
    assign push_req   = payload && cmd == 8'd1 && state == 4'd0;
    assign flush      = payload && cmd == 8'd5 && state == 4'd0;
    assign status_rd  = payload && cmd == 8'd0 && state == 4'd1;
    assign irq_arm    = payload && cmd == 8'd4 && state == 4'd0;
    assign pop        = drain_state == S_IDLE && level != '0;
    // A full FIFO still accepts a push when the drain frees a slot in the same cycle.
    assign push_ok    = push_req && (level != FULL_LVL || pop);
    assign push_entry = {data_in[7], keymap_col, keymap_row};
    assign pop_entry  = fifo_mem[rd_ptr];
    assign level_lo   = 4'(level);

    // NOTE: defaulting the output first keeps this block free of inferred latches.
    always_comb begin
        keyboard_matrix_in = '1;
        for (int c = 0; c < MATRIX_COLS; c++)
            if (!keyboard_matrix_out[c]) keyboard_matrix_in &= mat[c];
    end

    // NOTE: event storage carries no reset; level and pointers alone decide validity.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            drain_state   <= S_IDLE;
            hold_cnt      <= '0;
            mat           <= '1;
            fifo_overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            drain_state   <= S_IDLE;
            hold_cnt      <= '0;
            mat           <= '1;
            fifo_overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: ;
            endcase
            if (push_req && !push_ok) fifo_overflow <= 1'b1;
            else if (status_rd)       fifo_overflow <= 1'b0;
            case (drain_state)
                S_IDLE: if (pop) begin
                    mat[pop_entry[CW+RW-1:RW]][pop_entry[RW-1:0]] <= pop_entry[EW-1];
                    drain_state <= S_HOLD;
                    hold_cnt    <= HW'(HOLD_CYCLES - 1);
                end
                default: begin
                    if (hold_cnt == '0) drain_state <= S_IDLE;
                    else                hold_cnt    <= hold_cnt - HW'(1);
                end
            endcase
        end
    end

    // NOTE: all state below uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd <= '0; state <= '0; dev <= '0; data_out <= '0;
            joystick <= '0; joystick_ax <= '0; joystick_ay <= '0; extra_button <= '0;
            joystick_strobe <= '0; numpad <= '0;
            mouse_btns <= '0; mouse_x <= '0; mouse_y <= '0; mouse_strobe <= 1'b0;
        end else begin
            mouse_strobe    <= 1'b0;
            joystick_strobe <= '0;
            if (data_in_strobe && data_in_start) begin
                cmd   <= data_in;
                state <= '0;
            end else if (payload) begin
                if (state != 4'hF) state <= state + 4'd1;
                case (cmd)
                    8'd0: begin
                        if (state == 4'd0)      data_out <= 8'h01;
                        else if (state == 4'd1) data_out <= {fifo_overflow, 3'b000, level_lo};
                    end
                    8'd2: case (state)
                        4'd0: mouse_btns <= data_in[1:0];
                        4'd1: mouse_x    <= data_in;
                        4'd2: begin
                            mouse_y      <= data_in;
                            mouse_strobe <= 1'b1;
                        end
                        default: ;
                    endcase
                    8'd3: begin
                        if (state == 4'd0) dev <= data_in;
                        for (int j = 0; j < NUM_JOY; j++) begin
                            if (dev == 8'(j)) case (state)
                                4'd1: joystick[8*j +: 8]    <= data_in;
                                4'd2: joystick_ax[8*j +: 8] <= data_in;
                                4'd3: joystick_ay[8*j +: 8] <= data_in;
                                4'd4: begin
                                    extra_button[8*j +: 8] <= data_in;
                                    joystick_strobe[j]     <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                        if (dev == 8'h80 && state == 4'd1) numpad <= data_in;
                    end
                    8'd4: begin
                        data_out <= 8'h00;
                        for (int k = 0; k < NUM_DB9; k++)
                            if (state == 4'(k)) data_out <= {2'b00, db9_s2[6*k +: 6]};
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db9_s1 <= '0; db9_s2 <= '0; db9_prev <= '0;
            irq <= 1'b0; irq_enable <= 1'b0;
        end else begin
            db9_s1   <= db9_port;
            db9_s2   <= db9_s1;
            db9_prev <= db9_s2;
            if (iack)                                 irq <= 1'b0;
            else if (db9_s2 != db9_prev && irq_enable) irq <= 1'b1;
            if (irq_arm)                               irq_enable <= 1'b1;
            else if (db9_s2 != db9_prev)               irq_enable <= 1'b0;
        end
    end

endmodule
